// File: rtl/serial_cmp_pkg.sv
// ---------------------------------------------------------------------------
// serial_cmp_pkg
//   Shared definitions for the MSB-first serial compare datapath.
//   - ser_state_t : serializer FSM state encoding
//   - cnt_width() : bit-counter width for a given word width, never below 1
// ---------------------------------------------------------------------------
package serial_cmp_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    // $clog2(1) is 0, so a one-bit word still gets a one-bit counter.
    function automatic int cnt_width(input int w);
        int c;
        c = $clog2(w);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/serial_pair_serializer_msb_first.sv
// ---------------------------------------------------------------------------
// serial_pair_serializer_msb_first
//   Accepts a pair of WIDTH-bit words over valid/ready and streams them out
//   one bit pair per cycle, MSB first, to a serial magnitude comparator.
//   Between words one idle cycle asserts cmp_rst so the comparator starts
//   every pair from the equal state.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a_word/b_word valid
//   in_ready   out  block can accept a pair this cycle
//   a_word     in   [WIDTH] parallel operand A
//   b_word     in   [WIDTH] parallel operand B
//   a, b       out  serial bits of A/B, MSB first
//   bit_valid  out  a/b carry a real bit this cycle
//   first_bit  out  a/b carry the MSB
//   last_bit   out  a/b carry the LSB; comparator result is final
//   cmp_rst    out  active-high synchronous clear for the comparator
// ---------------------------------------------------------------------------
module serial_pair_serializer_msb_first
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_word,
    input  logic [WIDTH-1:0] b_word,
    output logic             a,
    output logic             b,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             cmp_rst
);

    if (WIDTH < 1) begin : g_bad_width
        $error("serial_pair_serializer_msb_first: WIDTH must be >= 1");
    end

    localparam int              CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0]   CNT_MAX = CW'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // in_ready is the idle decode, so in_valid alone accepts.
                if (in_valid) begin
                    a_sh_d  = a_word;
                    b_sh_d  = b_word;
                    cnt_d   = CNT_MAX;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q << 1;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Every output is a decode of registered state; nothing flows from
    // in_valid/a_word/b_word straight to an output.
    assign in_shift  = (state_q == ST_SHIFT);
    assign in_ready  = ~in_shift;
    assign cmp_rst   = ~in_shift;
    assign bit_valid = in_shift;
    assign a         = in_shift & a_sh_q[WIDTH-1];
    assign b         = in_shift & b_sh_q[WIDTH-1];
    assign first_bit = in_shift & (cnt_q == CNT_MAX);
    assign last_bit  = in_shift & (cnt_q == '0);

endmodule
